// File: rtl/contador_pkg.sv
// contador_pkg: mode encodings and parameter legality limits shared by the up/down counter.
package contador_pkg;
  localparam logic MODO_SATURA = 1'b0;
  localparam logic MODO_WRAP   = 1'b1;
  localparam int   WIDTH_MIN   = 2;
  localparam int   WIDTH_MAX   = 16;
endpackage

// File: rtl/contador_updown_next.sv
// contador_updown_next: combinational next-count and overflow/underflow event logic.
module contador_updown_next
  import contador_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             inc,
  input  logic             dec,
  input  logic             wrap,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q_next,
  output logic             ovf_ev,
  output logic             unf_ev
);
  localparam logic [WIDTH:0]   L_MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_MAX   = WIDTH'(MAX_VAL);
  logic [WIDTH:0]   w_up;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_ld;
  logic             w_do_inc;
  logic             w_do_dec;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_wrap;
  always_comb begin
    w_up     = {1'b0, Q} + (WIDTH+1)'(1);
    w_dn     = Q - WIDTH'(1);
    w_ld     = (load_val > L_MAX) ? L_MAX : load_val;
    w_do_inc = inc & ~dec & ~clr & ~load;
    w_do_dec = dec & ~inc & ~clr & ~load;
    w_at_max = w_up > L_MAX_X;
    w_at_min = (Q == '0);
    w_wrap   = (wrap == MODO_WRAP);
    ovf_ev   = w_do_inc & w_at_max;
    unf_ev   = w_do_dec & w_at_min;
    Q_next   = clr      ? '0 :
               load     ? w_ld :
               w_do_inc ? (w_at_max ? (w_wrap ? '0 : Q) : w_up[WIDTH-1:0]) :
               w_do_dec ? (w_at_min ? (w_wrap ? L_MAX : Q) : w_dn) :
               Q;
  end
endmodule

// File: rtl/contador_updown_param.sv
// contador_updown_param: parametrised up/down occupancy counter with saturate/wrap and threshold flags.
// Define CONTADOR_ERR_STICKY_EN to make ovf/unf sticky until clr or rst.
module contador_updown_param
  import contador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int AF_THRESH = MAX_VAL-1,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] Q,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             ovf,
  output logic             unf
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("contador_updown_param: WIDTH out of range");
  end
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("contador_updown_param: MAX_VAL out of range");
  end
  if (AF_THRESH < 0 || AF_THRESH > MAX_VAL) begin : g_bad_af
    $error("contador_updown_param: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > MAX_VAL) begin : g_bad_ae
    $error("contador_updown_param: AE_THRESH out of range");
  end
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   L_AF  = (WIDTH+1)'(AF_THRESH);
  localparam logic [WIDTH:0]   L_AE  = (WIDTH+1)'(AE_THRESH);
  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_ev;
  logic             w_unf_ev;
  contador_updown_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .Q        (r_q),
    .inc      (inc),
    .dec      (dec),
    .wrap     (wrap),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .Q_next   (w_q_next),
    .ovf_ev   (w_ovf_ev),
    .unf_ev   (w_unf_ev)
  );
  // events are already suppressed by clr, so pulse mode needs no explicit clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
`ifdef CONTADOR_ERR_STICKY_EN
      r_ovf <= ~clr & (r_ovf | w_ovf_ev);
      r_unf <= ~clr & (r_unf | w_unf_ev);
`else
      r_ovf <= w_ovf_ev;
      r_unf <= w_unf_ev;
`endif
    end
  end
  always_comb begin
    Q            = r_q;
    ovf          = r_ovf;
    unf          = r_unf;
    empty        = (r_q == '0);
    full         = (r_q == L_MAX);
    almost_empty = ({1'b0, r_q} <= L_AE);
    almost_full  = ({1'b0, r_q} >= L_AF);
  end
endmodule

// File: tb/tb_contador_updown_param.sv
// tb_contador_updown_param: directed checks of the up/down counter at WIDTH=3, MAX_VAL=5.
module tb_contador_updown_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;
  logic       wrap = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [2:0] Q;
  logic       empty, full, almost_empty, almost_full, ovf, unf;
  int n_tot = 0;
  int n_bad = 0;
`ifdef CONTADOR_ERR_STICKY_EN
  localparam int STK = 1;
`else
  localparam int STK = 0;
`endif

  contador_updown_param #(
    .WIDTH(3), .MAX_VAL(5), .AF_THRESH(4), .AE_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .wrap(wrap), .inc(inc), .dec(dec), .Q(Q), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int q, input int o, input int u);
    chk({tag, ".q"}, int'(Q), q);
    chk({tag, ".empty"}, int'(empty), int'(q == 0));
    chk({tag, ".full"}, int'(full), int'(q == 5));
    chk({tag, ".ae"}, int'(almost_empty), int'(q <= 1));
    chk({tag, ".af"}, int'(almost_full), int'(q >= 4));
    chk({tag, ".ovf"}, int'(ovf), o);
    chk({tag, ".unf"}, int'(unf), u);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic c, input logic l, input int lv, input logic w, input logic i, input logic d);
    clr = c; load = l; load_val = 3'(lv); wrap = w; inc = i; dec = d;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_all("rst_async", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    set(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all($sformatf("inc%0d", k), k, 0, 0);
    end
    tick();
    chk_all("sat_inc1", 5, 1, 0);
    tick();
    chk_all("sat_inc2", 5, 1, 0);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk_all("sat_idle", 5, STK, 0);
    set(1, 0, 0, 0, 0, 0);
    tick();
    chk_all("clr", 0, 0, 0);
    set(0, 0, 0, 0, 0, 1);
    tick();
    chk_all("sat_dec0", 0, 0, 1);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk_all("sat_dec_idle", 0, 0, STK);
    set(1, 0, 0, 0, 0, 0);
    tick();
    set(0, 1, 5, 1, 0, 0);
    tick();
    chk_all("load5", 5, 0, 0);
    set(0, 0, 0, 1, 1, 0);
    tick();
    chk_all("wrap_inc", 0, 1, 0);
    set(0, 0, 0, 1, 0, 1);
    tick();
    chk_all("wrap_dec", 5, STK, 1);
    set(1, 0, 0, 0, 0, 0);
    tick();
    set(0, 1, 5, 0, 0, 0);
    tick();
    set(0, 0, 0, 0, 1, 1);
    tick();
    chk_all("incdec_max", 5, 0, 0);
    set(0, 1, 0, 0, 0, 0);
    tick();
    set(0, 0, 0, 1, 1, 1);
    tick();
    chk_all("incdec_zero", 0, 0, 0);
    set(1, 1, 3, 0, 1, 0);
    tick();
    chk_all("clr_prio", 0, 0, 0);
    set(0, 1, 7, 0, 0, 0);
    tick();
    chk_all("load_clamp", 5, 0, 0);
    set(0, 1, 2, 0, 0, 0);
    tick();
    chk_all("load2", 2, 0, 0);
    set(0, 1, 1, 0, 1, 0);
    tick();
    chk_all("load_over_inc", 1, 0, 0);
    if (STK != 0) begin
      set(0, 1, 5, 0, 0, 0);
      tick();
      set(0, 0, 0, 0, 1, 0);
      tick();
      chk_all("stk_set", 5, 1, 0);
      set(0, 0, 0, 0, 0, 1);
      tick();
      chk_all("stk_dec", 4, 1, 0);
      set(0, 1, 2, 0, 0, 0);
      tick();
      chk_all("stk_load", 2, 1, 0);
      set(1, 0, 0, 0, 0, 0);
      tick();
      chk_all("stk_clr", 0, 0, 0);
    end
    set(0, 1, 3, 0, 0, 0);
    tick();
    chk_all("pre_rst", 3, 0, 0);
    set(0, 0, 0, 0, 1, 0);
    #1 rst = 1'b1;
    #1 chk_all("mid_rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_all("post_rst_inc", 1, 0, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/contador_updown_param.md
# contador_updown_param

Parametrised up/down occupancy counter with saturate or wrap modes, synchronous clear and load, threshold flags and overflow/underflow indication. It is the general-width successor of the 2-bit saturating counter. It serves as the occupancy and credit tracker for buffers and the ULA control path. The count is held in registers and all flags derive from the registered count, so they are glitch-free relative to `clk`.

## Interface
- `WIDTH`, 4: counter width in bits; legal range is 2..16.
- `MAX_VAL`, 2**WIDTH-1: terminal count; legal range is 1..2**WIDTH-1.
- `AF_THRESH`, MAX_VAL-1: `almost_full` asserts when Q >= AF_THRESH.
- `AE_THRESH`, 1: `almost_empty` asserts when Q <= AE_THRESH.
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value to load.
- `wrap`  in  1  mode select: 0 = saturate, 1 = wrap modulo MAX_VAL+1.
- `inc`  in  1  increment request.
- `dec`  in  1  decrement request.
- `Q`  out  WIDTH  current count.
- `empty`  out  1  asserted when Q == 0.
- `full`  out  1  asserted when Q == MAX_VAL.
- `almost_empty`  out  1  asserted when Q <= AE_THRESH.
- `almost_full`  out  1  asserted when Q >= AF_THRESH.
- `ovf`  out  1  overflow indication; a registered signal.
- `unf`  out  1  underflow indication; a registered signal.

## Operation
- Priority at each rising edge: `rst` (async) > `clr` > `load` > `inc`/`dec`.
- Reset state: Q=0, `ovf`=0, `unf`=0.
  - Resulting flags: `empty`=1, `full`=0.
  - `almost_empty`=1 because AE_THRESH >= 0.
  - `almost_full`=(AF_THRESH==0).
- `clr` sets Q=0 and clears `ovf` and `unf`.
- `load` with `load_val` > MAX_VAL: Q is set to MAX_VAL (clamped).
- `load` with `load_val` <= MAX_VAL: Q is set to `load_val`.
- `load` does not raise `ovf`/`unf`.
- `inc`=1 and `dec`=1 together: Q holds and no flag is raised, including at the boundaries.
- Otherwise, increment or decrement by 1:
  - `inc` at Q==MAX_VAL in saturate mode: Q holds and `ovf` fires.
  - `inc` at Q==MAX_VAL in wrap mode: Q becomes 0 and `ovf` fires as a carry indication.
  - `dec` at Q==0 in saturate mode: Q holds and `unf` fires.
  - `dec` at Q==0 in wrap mode: Q becomes MAX_VAL and `unf` fires.
- Arithmetic is performed at WIDTH+1 bits internally, then compared against MAX_VAL. There is no silent modulo-2**WIDTH wrap when MAX_VAL < 2**WIDTH-1.
- `wrap` is sampled on every edge, so a mode change takes effect on the next operation.
- `empty`, `full`, `almost_empty` and `almost_full` are purely combinational from Q.

## Timing
- Latency of Q: 1 cycle from a request sampled at edge N to Q valid after edge N.
- Threshold flags follow Q in the same cycle, with no extra latency.
- `ovf`/`unf` are registered at the same edge as Q.
  - In pulse mode they are high for exactly the one cycle following the offending edge.
- `rst` assertion clears Q and the flags immediately, without waiting for `clk`.
- Reset deassertion: the first operative edge is the next rising `clk` edge.
- `rst` asserted mid-operation discards any in-flight request.
- There is no back-pressure: requests are accepted every cycle.

## Configuration
- `CONTADOR_ERR_STICKY_EN`
  - Defined: `ovf`/`unf` are sticky. Once set they stay high until `clr` or `rst`. `load` does not clear them.
  - Undefined: `ovf`/`unf` are single-cycle pulses, as described in Timing.

## Structure
- Shared package `contador_pkg` holds:
  - mode encoding constants `MODO_SATURA`=1'b0 and `MODO_WRAP`=1'b1;
  - the parameter legality limits (`WIDTH_MIN`=2, `WIDTH_MAX`=16).
- Sub-module `contador_updown_next`: combinational next-state logic.
  - Inputs: Q, `inc`, `dec`, `wrap`, `clr`, `load`, `load_val`.
  - Outputs: Q_next, `ovf_ev`, `unf_ev`.
- The top level holds the registers, the sticky/pulse logic and the flag decode.
- The parameter checks (MAX_VAL and thresholds within range) are elaboration-time assertions at the top level.

## Test plan
All scenarios use WIDTH=3, MAX_VAL=5, AF_THRESH=4, AE_THRESH=1.
- Reset: assert `rst` with no clock -> Q=0, `empty`=1, `almost_empty`=1, `full`=0, `ovf`=`unf`=0 immediately. Release `rst`, then `inc` for 5 cycles -> Q steps 1,2,3,4,5. `almost_full` is high from Q=4 and `full` from Q=5.
- Saturate: Q=5, `wrap`=0, `inc` for 2 cycles -> Q stays 5 and `ovf` is high in both following cycles (pulse mode). Q=0 with `dec` -> Q stays 0 and `unf`=1 for one cycle.
- Wrap: Q=5, `wrap`=1, `inc` -> Q=0 and `ovf` pulses. `dec` at Q=0 -> Q=5 and `unf` pulses.
- Simultaneous and priority:
  - Q=5 with `inc`=`dec`=1 -> Q=5 and no flags.
  - `clr`=`load`=`inc`=1 -> Q=0.
  - `load` with `load_val`=7 -> Q=5 (clamped) and no `ovf`.
- Sticky (build with `CONTADOR_ERR_STICKY_EN` defined): force `ovf` -> it stays 1 through later `inc`/`dec`/`load` activity, then drops the cycle after `clr`.
- Mid-operation reset: `rst` pulse between clock edges while Q=3 and `inc`=1 -> Q=0 at once. After release, the next edge with `inc` gives Q=1.
